operm_ctrl_n_1: RTL and testbench
=================================

Name: operm_ctrl_n_1

Overview:
- Parametrised N-to-1 operand-permute controller, successor to the fixed 2-input permute control.
- Joins one kernel/program (kp) token carrying an opcode with a per-opcode subset of N data-channel tokens.
- Pushes one merged descriptor (select mask plus opcode) into an output buffer that feeds the downstream datapath.
- Invalid opcodes are consumed and dropped without touching data channels; output timing is fully registered.

Parameters:
- N, 2, number of data target channels (1..8).
- KW, 4, opcode width of k_ctrl.
- VALID_MASK, 16'hE300, bit k set means opcode k is legal (default: 8, 9, 13, 14, 15).
- USE_MAP, {16{2'b11}}, N bits per opcode (opcode k uses bits [k*N +: N]); bit i set means the opcode consumes data channel i.
- OBUF_DEPTH, 2, output buffer entries (power of two, at least 2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- t_dat_req  in  N  data channel i has a token
- t_dat_ack  out  N  data channel i token consumed this cycle
- t_kp_req  in  1  kp token valid
- t_kp_ack  out  1  kp token consumed this cycle
- k_ctrl  in  KW  opcode of the kp token, valid while t_kp_req is high
- i_dat_req  out  1  output descriptor valid (head of buffer)
- i_dat_ack  in  1  downstream accepts the head descriptor
- i_dat_sel  out  N  channels joined for the head descriptor
- i_op  out  KW  opcode of the head descriptor
- err_cnt  out  16  count of invalid opcodes dropped

Behaviour:
- A transfer occurs on any channel in a cycle where req and ack are both high. A source holds req and payload stable until ack.
- Decode, all combinational from k_ctrl:
  - op_ok = VALID_MASK[k_ctrl]
  - need = USE_MAP[k_ctrl*N +: N]
- Fire condition: fire = t_kp_req & op_ok & ~full & AND over i of (t_dat_req[i] | ~need[i]).
- Acknowledges:
  - t_dat_ack[i] = fire & need[i]. Channels not in need are never acked, even if requesting.
  - t_kp_ack = fire | (t_kp_req & ~op_ok).
- Invalid opcode:
  - The kp token is consumed in one cycle regardless of buffer fullness or data presence.
  - No data ack, no push.
  - err_cnt increments, saturating at 16'hFFFF.
- Valid opcode with need == 0: fires on kp alone (only buffer space is required) and pushes i_dat_sel = 0.
- Push on fire: write {need, k_ctrl} at wr_ptr, wr_ptr++.
- Output buffer: circular FIFO of OBUF_DEPTH entries, with pointers wrapping modulo OBUF_DEPTH.
  - i_dat_req = (count != 0).
  - i_dat_sel and i_op come from the rd_ptr entry.
  - Pop when i_dat_req & i_dat_ack, then rd_ptr++.
- Full: full = (count == OBUF_DEPTH), computed from registered count only.
  - A pop in the same cycle does not enable a push; this keeps i_dat_ack free of any combinational path to the t_* acks.
  - A push and a pop together with 0 < count < OBUF_DEPTH leaves count unchanged.
- Latency: a descriptor appears on i_dat_req one cycle after its fire cycle.
  - Sustained throughput is 1 descriptor per cycle when OBUF_DEPTH >= 2 and downstream always acks.
- Ordering: strictly in kp order; there is no reordering.
- Reset (synchronous, any time including mid-operation):
  - count, pointers and err_cnt are cleared to 0, so i_dat_req = 0.
  - Buffered descriptors are discarded.
  - While reset is high, t_dat_ack = 0 and t_kp_ack = 0.
  - i_dat_sel and i_op read 0 after reset; buffer storage is cleared.
- X-safety: when t_kp_req = 0, k_ctrl is ignored and no ack or count change occurs.

Optional Feature:
- Macro: OPERM_CTRL_N_1_ERR_CNT_EN.
- Defined: err_cnt counter implemented as above.
- Undefined: counter logic is removed and err_cnt is tied to 16'h0. Invalid-op drop behaviour is unchanged.

Decomposition:
- Shared package operm_pkg holds:
  - opcode width constant OPERM_KW = 4
  - default VALID_MASK and USE_MAP constants
  - descriptor typedef operm_desc_t {sel, op}
- One sub-module, operm_obuf: a parametrised synchronous FIFO of operm_desc_t with push/full/pop/empty. It is reusable by the other operm controllers.
- The join/decode logic stays in the top level.

Test Plan:
- Happy path (N=2, defaults): both data reqs = 1, kp with op=8 → same-cycle t_dat_ack = 2'b11 and t_kp_ack = 1; next cycle i_dat_req = 1, i_dat_sel = 2'b11, i_op = 8.
- Invalid opcode: kp op=3 with both data reqs high → t_kp_ack = 1, t_dat_ack = 0, no push, err_cnt goes 0→1. Drive 70000 invalid ops → err_cnt holds at 16'hFFFF.
- Partial use (USE_MAP op 9 = 2'b01): only t_dat_req[0] = 1 → fires, t_dat_ack = 2'b01; channel 1 token remains pending.
- Backpressure: i_dat_ack = 0, issue 3 valid ops → 2 accepted, third kp held with t_kp_ack = 0. Assert i_dat_ack for one cycle → third accepted one cycle later (no same-cycle push while full); output order is 1, 2, 3.
- Missing data: kp op=13 with t_dat_req = 2'b10 → no acks. Raise t_dat_req[0] → fire in that cycle.
- Reset mid-stream: buffer holding 2 entries, reset high for 1 cycle → i_dat_req = 0 and all acks 0 during reset, err_cnt = 0, and no stale descriptor emerges afterwards.

Source files
------------

// File: rtl/operm_pkg.sv
// operm_pkg - shared definitions for the operand-permute controllers.
//   OPERM_KW          opcode width
//   OPERM_MAX_N       widest data-channel select carried in a descriptor
//   OPERM_VALID_MASK  default legal-opcode mask (opcodes 8, 9, 13, 14, 15)
//   OPERM_USE_MAP     default per-opcode channel-use map (2 channels, all used)
//   operm_desc_t      buffered descriptor {sel, op}
package operm_pkg;

  localparam int unsigned OPERM_KW    = 4;
  localparam int unsigned OPERM_MAX_N = 8;

  localparam logic [15:0] OPERM_VALID_MASK = 16'hE300;
  localparam logic [31:0] OPERM_USE_MAP    = {16{2'b11}};

  // sel is sized for the widest controller; narrower users zero the top bits.
  typedef struct packed {
    logic [OPERM_MAX_N-1:0] sel;
    logic [OPERM_KW-1:0]    op;
  } operm_desc_t;

endpackage

// File: rtl/operm_obuf.sv
// operm_obuf - synchronous circular FIFO of operm_desc_t.
//   clk, reset  clock, synchronous active-high reset (clears storage too)
//   push        write wr_data at the tail (ignored when full)
//   wr_data     descriptor to write
//   full        count == DEPTH, from registered state only
//   pop         drop the head entry (ignored when empty)
//   empty       count == 0
//   rd_data     head entry
// DEPTH must be a power of two (>= 2) so pointers wrap naturally.
module operm_obuf
  import operm_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  operm_desc_t wr_data,
  output logic        full,
  input  logic        pop,
  output logic        empty,
  output operm_desc_t rd_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  operm_desc_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    rd_data = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/operm_ctrl_n_1.sv
// operm_ctrl_n_1 - N-to-1 operand-permute controller.
// Joins a kp token (opcode k_ctrl) with the opcode's subset of N data
// tokens and pushes a {sel, op} descriptor into an output FIFO.
// Illegal opcodes are consumed immediately and counted.
//   clk, reset          clock, synchronous active-high reset
//   t_dat_req/t_dat_ack data-channel handshakes (N bits)
//   t_kp_req/t_kp_ack   kp-token handshake, k_ctrl = opcode
//   i_dat_req/i_dat_ack head-descriptor handshake, i_dat_sel/i_op = head
//   err_cnt             saturating count of dropped illegal opcodes
// Optional: define OPERM_CTRL_N_1_ERR_CNT_EN to build err_cnt; otherwise
// err_cnt is tied to zero.
module operm_ctrl_n_1
  import operm_pkg::*;
#(
  parameter int                     N          = 2,
  parameter int                     KW         = OPERM_KW,
  parameter logic [(2**KW)-1:0]     VALID_MASK = OPERM_VALID_MASK,
  parameter logic [(2**KW)*N-1:0]   USE_MAP    = OPERM_USE_MAP,
  parameter int                     OBUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  t_dat_req,
  output logic [N-1:0]  t_dat_ack,
  input  logic          t_kp_req,
  output logic          t_kp_ack,
  input  logic [KW-1:0] k_ctrl,
  output logic          i_dat_req,
  input  logic          i_dat_ack,
  output logic [N-1:0]  i_dat_sel,
  output logic [KW-1:0] i_op,
  output logic [15:0]   err_cnt
);

  logic        op_ok;
  logic [N-1:0] need;
  logic        dat_ok;
  logic        fire;
  logic        drop;
  logic        full;
  logic        empty;
  operm_desc_t wr_desc;
  operm_desc_t rd_desc;
  logic        unused_desc;

  // full comes from the registered FIFO count only, so a pop in this cycle
  // never frees space for a push in the same cycle; this keeps i_dat_ack
  // off every combinational path into the t_* acknowledges.
  always_comb begin
    op_ok     = VALID_MASK[k_ctrl];
    need      = USE_MAP[int'(k_ctrl)*N +: N];
    dat_ok    = &(t_dat_req | ~need);
    fire      = ~reset & t_kp_req & op_ok & ~full & dat_ok;
    drop      = ~reset & t_kp_req & ~op_ok;
    t_dat_ack = fire ? need : '0;
    t_kp_ack  = fire | drop;

    wr_desc          = '0;
    wr_desc.sel[N-1:0] = need;
    wr_desc.op       = OPERM_KW'(k_ctrl);

    i_dat_req = ~empty;
    i_dat_sel = rd_desc.sel[N-1:0];
    i_op      = KW'(rd_desc.op);
  end

  assign unused_desc = ^rd_desc;

  operm_obuf #(
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk     (clk),
    .reset   (reset),
    .push    (fire),
    .wr_data (wr_desc),
    .full    (full),
    .pop     (i_dat_ack),
    .empty   (empty),
    .rd_data (rd_desc)
  );

`ifdef OPERM_CTRL_N_1_ERR_CNT_EN
  logic [15:0] err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else if (drop && (err_q != '1)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_operm_ctrl_n_1.sv
// tb_operm_ctrl_n_1 - scoreboard bench for operm_ctrl_n_1 (N=2, depth 2).
// A driver applies directed and random stimulus, predicts acknowledges from
// an opcode table and pushes expected descriptors; a monitor pops and
// compares whenever the DUT presents a descriptor.
module tb_operm_ctrl_n_1;
  import operm_pkg::*;

  localparam int N     = 2;
  localparam int KW    = 4;
  localparam int DEPTH = 2;
  // op15=10, op14=00, op13..10=11, op9=01, op8=11, op7..0=11
  localparam logic [31:0] TB_USE_MAP = 32'h8FF7_FFFF;

  logic          clk;
  logic          reset;
  logic [N-1:0]  t_dat_req;
  logic [N-1:0]  t_dat_ack;
  logic          t_kp_req;
  logic          t_kp_ack;
  logic [KW-1:0] k_ctrl;
  logic          i_dat_req;
  logic          i_dat_ack;
  logic [N-1:0]  i_dat_sel;
  logic [KW-1:0] i_op;
  logic [15:0]   err_cnt;

  operm_ctrl_n_1 #(
    .N          (N),
    .KW         (KW),
    .VALID_MASK (16'hE300),
    .USE_MAP    (TB_USE_MAP),
    .OBUF_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .t_dat_req (t_dat_req),
    .t_dat_ack (t_dat_ack),
    .t_kp_req  (t_kp_req),
    .t_kp_ack  (t_kp_ack),
    .k_ctrl    (k_ctrl),
    .i_dat_req (i_dat_req),
    .i_dat_ack (i_dat_ack),
    .i_dat_sel (i_dat_sel),
    .i_op      (i_op),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] op;
  } exp_t;

  exp_t        exp_q[$];
  bit          legal_tbl[16];
  logic [1:0]  need_tbl[16];
  int          valid_ops[5] = '{8, 9, 13, 14, 15};
  int unsigned err_exp;
  int unsigned n_tests;
  int unsigned n_fail;
  bit          mon_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] err_ref();
`ifdef OPERM_CTRL_N_1_ERR_CNT_EN
    return 16'(err_exp);
`else
    return 16'h0;
`endif
  endfunction

  // One clock of stimulus; entered and left just after a rising edge.
  task automatic step(input bit kp, input logic [3:0] op, input logic [1:0] dreq,
                      input bit oack, output bit kp_ack_e, output logic [1:0] dat_ack_e);
    bit push_e;
    bit inv_e;
    t_kp_req  = kp;
    k_ctrl    = op;
    t_dat_req = dreq;
    i_dat_ack = oack;
    @(negedge clk);
    kp_ack_e  = 1'b0;
    dat_ack_e = 2'b00;
    push_e    = 1'b0;
    inv_e     = 1'b0;
    if (kp) begin
      if (!legal_tbl[op]) begin
        kp_ack_e = 1'b1;
        inv_e    = 1'b1;
      end else if (((dreq & need_tbl[op]) == need_tbl[op]) && (exp_q.size() < DEPTH)) begin
        kp_ack_e  = 1'b1;
        dat_ack_e = need_tbl[op];
        push_e    = 1'b1;
      end
    end
    check("t_kp_ack", 32'(t_kp_ack), 32'(kp_ack_e));
    check("t_dat_ack", 32'(t_dat_ack), 32'(dat_ack_e));
    check("err_cnt", 32'(err_cnt), 32'(err_ref()));
    @(posedge clk);
    if (push_e) exp_q.push_back('{sel: need_tbl[op], op: op});
    if (inv_e && err_exp < 32'hFFFF) err_exp++;
    #1;
  endtask

  task automatic idle(input int cycles);
    bit         ka;
    logic [1:0] da;
    for (int i = 0; i < cycles; i++) step(1'b0, 4'($urandom), 2'b00, 1'b1, ka, da);
  endtask

  task automatic do_reset();
    t_kp_req  = 1'b1;
    k_ctrl    = 4'd8;
    t_dat_req = 2'b11;
    i_dat_ack = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    check("rst_kp_ack", 32'(t_kp_ack), 32'd0);
    check("rst_dat_ack", 32'(t_dat_ack), 32'd0);
    @(posedge clk);
    exp_q.delete();
    err_exp = 0;
    #1;
    reset     = 1'b0;
    t_kp_req  = 1'b0;
    t_dat_req = 2'b00;
    @(negedge clk);
    check("rst_o_req", 32'(i_dat_req), 32'd0);
    check("rst_o_sel", 32'(i_dat_sel), 32'd0);
    check("rst_o_op", 32'(i_op), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the head descriptor against the scoreboard each cycle.
  initial begin
    bit pop;
    forever begin
      @(negedge clk);
      pop = 1'b0;
      if (mon_en) begin
        check("i_dat_req", 32'(i_dat_req), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          check("i_dat_sel", 32'(i_dat_sel), 32'(exp_q[0].sel));
          check("i_op", 32'(i_op), 32'(exp_q[0].op));
          pop = i_dat_ack;
        end
      end
      @(posedge clk);
      if (pop) void'(exp_q.pop_front());
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ka;
    logic [1:0] da;
    logic [1:0] dtok;
    bit         kp_tok;
    logic [3:0] kp_op;

    n_tests = 0;
    n_fail  = 0;
    err_exp = 0;
    mon_en  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      legal_tbl[k] = 1'b0;
      need_tbl[k]  = 2'b11;
    end
    foreach (valid_ops[i]) legal_tbl[valid_ops[i]] = 1'b1;
    need_tbl[9]  = 2'b01;
    need_tbl[14] = 2'b00;
    need_tbl[15] = 2'b10;

    reset     = 1'b1;
    t_kp_req  = 1'b0;
    t_dat_req = 2'b00;
    k_ctrl    = 4'd0;
    i_dat_ack = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    mon_en = 1'b1;

    // happy path
    step(1'b1, 4'd8, 2'b11, 1'b1, ka, da);
    idle(2);
    // illegal opcode with data present
    step(1'b1, 4'd3, 2'b11, 1'b1, ka, da);
    idle(1);
    // partial use: op 9 takes channel 0 only, channel 1 stays pending
    step(1'b1, 4'd9, 2'b01, 1'b1, ka, da);
    step(1'b0, 4'd0, 2'b10, 1'b1, ka, da);
    step(1'b0, 4'd0, 2'b10, 1'b1, ka, da);
    step(1'b1, 4'd15, 2'b10, 1'b1, ka, da);
    // opcode with empty use set fires on kp alone
    step(1'b1, 4'd14, 2'b00, 1'b1, ka, da);
    idle(2);
    // missing data, then the missing channel arrives
    step(1'b1, 4'd13, 2'b10, 1'b1, ka, da);
    step(1'b1, 4'd13, 2'b10, 1'b1, ka, da);
    step(1'b1, 4'd13, 2'b11, 1'b1, ka, da);
    idle(3);
    // backpressure: two accepted, third held until a pop frees space
    step(1'b1, 4'd8, 2'b11, 1'b0, ka, da);
    step(1'b1, 4'd13, 2'b11, 1'b0, ka, da);
    step(1'b1, 4'd9, 2'b01, 1'b0, ka, da);
    step(1'b1, 4'd9, 2'b01, 1'b0, ka, da);
    step(1'b1, 4'd9, 2'b01, 1'b1, ka, da);
    step(1'b1, 4'd9, 2'b01, 1'b0, ka, da);
    idle(4);
    // reset with two descriptors buffered
    step(1'b1, 4'd8, 2'b11, 1'b0, ka, da);
    step(1'b1, 4'd15, 2'b10, 1'b0, ka, da);
    step(1'b1, 4'd3, 2'b00, 1'b0, ka, da);
    do_reset();
    idle(4);

    // random traffic honouring hold-until-ack on every source
    dtok   = 2'b00;
    kp_tok = 1'b0;
    kp_op  = 4'd0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if (!dtok[i] && $urandom_range(0, 1) == 1) dtok[i] = 1'b1;
      if (!kp_tok && $urandom_range(0, 2) != 0) begin
        kp_tok = 1'b1;
        if ($urandom_range(0, 9) < 7) kp_op = 4'(valid_ops[$urandom_range(0, 4)]);
        else kp_op = 4'($urandom_range(0, 15));
      end
      step(kp_tok, kp_tok ? kp_op : 4'($urandom), dtok, $urandom_range(0, 3) != 0, ka, da);
      dtok = dtok & ~da;
      if (ka) kp_tok = 1'b0;
    end
    idle(4);

`ifdef OPERM_CTRL_N_1_ERR_CNT_EN
    for (int c = 0; c < 70000; c++) step(1'b1, 4'd3, 2'b11, 1'b1, ka, da);
    @(negedge clk);
    check("err_cnt_sat", 32'(err_cnt), 32'hFFFF);
    @(posedge clk);
    #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
